// File: rtl/weight_lfsr_bank_param_if.sv
// Control/status bundle for the weight LFSR bank. The master side (the
// sequencer or a bench) drives loads, steps, read/compute selects and scan
// starts. The slave side (the bank) returns the registered row bus and the
// scan status.
interface weight_lfsr_bank_param_if #(
    parameter int N_R        = 81,
    parameter int LFSR_WIDTH = 5,
    parameter int FXP        = 6,
    parameter int SEL_W      = $clog2(N_R),
    parameter int ADDR_W     = $clog2(N_R*FXP)
);
    logic                   lfsr_load;
    logic                   lfsr_load_all;
    logic [SEL_W-1:0]       lfsr_sel;
    logic [LFSR_WIDTH-1:0]  LFSR_REG_INIT;
    logic                   lfsr_en;
    logic                   lfsr_option_sel;
    logic                   read_en;
    logic                   compute_en;
    logic [ADDR_W-1:0]      READ_ADDR;
    logic                   scan_start;
    logic                   scan_busy;
    logic                   scan_done;
    logic [N_R*FXP-1:0]     LFSR;

    modport master (
        output lfsr_load, lfsr_load_all, lfsr_sel, LFSR_REG_INIT, lfsr_en,
               lfsr_option_sel, read_en, compute_en, READ_ADDR, scan_start,
        input  scan_busy, scan_done, LFSR
    );

    modport slave (
        input  lfsr_load, lfsr_load_all, lfsr_sel, LFSR_REG_INIT, lfsr_en,
               lfsr_option_sel, read_en, compute_en, READ_ADDR, scan_start,
        output scan_busy, scan_done, LFSR
    );
endinterface

// File: rtl/weight_lfsr_bank_param.sv
// Weight-stimulus generator for the compute array: one Fibonacci LFSR per
// array row, plus a registered output bus that carries a one-hot scan sweep,
// a one-hot read select, the per-row LFSR weights, or zero.

// One row's LFSR. Load and step controls are resolved by the bank; the row
// applies load-over-step and the selected tap polynomial.
module weight_lfsr_row #(
    parameter int                W      = 5,
    parameter logic [W-1:0]      TAPS_A = 5'b10100,
    parameter logic [W-1:0]      TAPS_B = 5'b11000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         step_i,
    input  logic         opt_i,
    output logic [W-1:0] state_o
);
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] taps;
    logic         fb;

    // Next state: seed wins over a step; otherwise hold.
    always_comb begin
        taps    = opt_i ? TAPS_B : TAPS_A;
        fb      = ^(state_q & taps);
        state_d = state_q;
        if (load_i)
            state_d = seed_i;
        else if (step_i)
            state_d = {state_q[W-2:0], fb};
    end

    // State register; reset to 1 so no row ever starts locked at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= W'(1);
        else
            state_q <= state_d;
    end

    assign state_o = state_q;
endmodule

module weight_lfsr_bank_param #(
    parameter int                      N_R        = 81,
    parameter int                      LFSR_WIDTH = 5,
    parameter int                      FXP        = 6,
    parameter logic [LFSR_WIDTH-1:0]   TAPS_A     = 5'b10100,
    parameter logic [LFSR_WIDTH-1:0]   TAPS_B     = 5'b11000,
    parameter int                      SEL_W      = $clog2(N_R),
    parameter int                      ADDR_W     = $clog2(N_R*FXP)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    weight_lfsr_bank_param_if.slave    bus
);
    localparam int                 TOTAL   = N_R * FXP;
    localparam logic [ADDR_W-1:0]  LAST    = ADDR_W'(TOTAL - 1);
    localparam logic [TOTAL-1:0]   ONE_HOT = TOTAL'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    scan_state_e                       scan_st_q;
    logic [ADDR_W-1:0]                 scan_addr_q;
    logic                              scan_busy_q;
    logic                              scan_done_q;

    logic [N_R-1:0][LFSR_WIDTH-1:0]    state;
    logic [N_R-1:0][FXP-1:0]           weights;
    logic [LFSR_WIDTH-1:0]             seed_eff;
    logic [TOTAL-1:0]                  lfsr_q, lfsr_d;

    // A zero seed would lock an LFSR at zero forever; substitute 1.
    assign seed_eff = (bus.LFSR_REG_INIT == '0) ? LFSR_WIDTH'(1)
                                                : bus.LFSR_REG_INIT;

    // Row bank. An out-of-range lfsr_sel never matches any row index, so it
    // loads nothing. Broadcast and per-row loads use the same seed, so
    // OR-ing them preserves the broadcast-first precedence.
    generate
        for (genvar r = 0; r < N_R; r++) begin : g_row
            logic load_row;
            assign load_row = bus.lfsr_load_all |
                              (bus.lfsr_load && (bus.lfsr_sel == SEL_W'(r)));

            weight_lfsr_row #(
                .W      (LFSR_WIDTH),
                .TAPS_A (TAPS_A),
                .TAPS_B (TAPS_B)
            ) u_row (
                .clk_i   (CLK),
                .rst_i   (RESET),
                .load_i  (load_row),
                .seed_i  (seed_eff),
                .step_i  (bus.lfsr_en),
                .opt_i   (bus.lfsr_option_sel),
                .state_o (state[r])
            );

            assign weights[r] = FXP'(state[r]);
        end
    endgenerate

    // Scan sequencer: IDLE -> SCAN (one bit index per cycle) -> DONE (one
    // cycle) -> IDLE. Starts are ignored while busy, and the address stops
    // at the last index instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_st_q   <= S_IDLE;
            scan_addr_q <= '0;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            case (scan_st_q)
                S_IDLE: begin
                    scan_done_q <= 1'b0;
                    if (bus.scan_start) begin
                        scan_st_q   <= S_SCAN;
                        scan_addr_q <= '0;
                        scan_busy_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (scan_addr_q == LAST) begin
                        scan_st_q   <= S_DONE;
                        scan_done_q <= 1'b1;
                    end else begin
                        scan_addr_q <= scan_addr_q + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    scan_st_q   <= S_IDLE;
                    scan_busy_q <= 1'b0;
                    scan_done_q <= 1'b0;
                end
                default: begin
                    scan_st_q   <= S_IDLE;
                    scan_busy_q <= 1'b0;
                    scan_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mux: scan, then read, then weights, then zero. A shift past the
    // bus width yields zero, which covers an out-of-range READ_ADDR. The
    // weights use the row states from before this edge's update.
    always_comb begin
        lfsr_d = '0;
        if (scan_st_q == S_SCAN)
            lfsr_d = ONE_HOT << scan_addr_q;
        else if (bus.read_en)
            lfsr_d = ONE_HOT << bus.READ_ADDR;
        else if (bus.compute_en)
            lfsr_d = weights;
    end

    // Registered output bus feeding the row drivers.
    always_ff @(posedge CLK) begin
        if (RESET)
            lfsr_q <= '0;
        else
            lfsr_q <= lfsr_d;
    end

    assign bus.LFSR      = lfsr_q;
    assign bus.scan_busy = scan_busy_q;
    assign bus.scan_done = scan_done_q;
endmodule

// File: tb/tb_weight_lfsr_bank_param.sv
// Bench for weight_lfsr_bank_param at N_R=4, LFSR_WIDTH=5, FXP=6. A
// cycle-level reference model built from integer arrays predicts the output
// bus and scan status on every cycle. Directed plan steps come first, then
// a randomized run.
module tb_weight_lfsr_bank_param;
    localparam int N_R   = 4;
    localparam int LW    = 5;
    localparam int FXP   = 6;
    localparam int TOTAL = N_R * FXP;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: row values as plain integers; scan position counts
    // cycles since an accepted start (-1 = not scanning).
    int   m_state [N_R];
    int   m_since = -1;

    weight_lfsr_bank_param_if #(.N_R(N_R), .LFSR_WIDTH(LW), .FXP(FXP)) bus ();

    weight_lfsr_bank_param #(
        .N_R(N_R), .LFSR_WIDTH(LW), .FXP(FXP),
        .TAPS_A(5'b10100), .TAPS_B(5'b11000)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // One clock: predict from the current inputs and model state, advance
    // the model, let the DUT take the edge, then compare.
    task automatic tick();
        logic [TOTAL-1:0] one;
        logic [TOTAL-1:0] exp_o;
        int taps;
        int seed;
        one   = TOTAL'(1);
        exp_o = '0;
        if (!RESET) begin
            if (m_since >= 0 && m_since < TOTAL)
                exp_o = one << m_since;
            else if (bus.read_en)
                exp_o = (int'(bus.READ_ADDR) < TOTAL) ? (one << bus.READ_ADDR) : '0;
            else if (bus.compute_en)
                for (int r = 0; r < N_R; r++) exp_o[r*FXP +: FXP] = 6'(m_state[r]);
        end
        if (RESET) begin
            for (int r = 0; r < N_R; r++) m_state[r] = 1;
            m_since = -1;
        end else begin
            taps = bus.lfsr_option_sel ? 'b11000 : 'b10100;
            seed = (bus.LFSR_REG_INIT == 0) ? 1 : int'(bus.LFSR_REG_INIT);
            for (int r = 0; r < N_R; r++) begin
                if (bus.lfsr_load_all || (bus.lfsr_load && int'(bus.lfsr_sel) == r))
                    m_state[r] = seed;
                else if (bus.lfsr_en)
                    m_state[r] = ((m_state[r] * 2) % 32) + ($countones(m_state[r] & taps) % 2);
            end
            if (m_since < 0)
                m_since = bus.scan_start ? 0 : -1;
            else if (m_since == TOTAL)
                m_since = -1;
            else
                m_since = m_since + 1;
        end
        @(posedge CLK);
        #1;
        chk("LFSR", 32'(bus.LFSR), 32'(exp_o));
        chk("scan_busy", 32'(bus.scan_busy), 32'(m_since >= 0));
        chk("scan_done", 32'(bus.scan_done), 32'(m_since == TOTAL));
    endtask

    task automatic idle_inputs();
        bus.lfsr_load = 0; bus.lfsr_load_all = 0; bus.lfsr_sel = '0;
        bus.LFSR_REG_INIT = '0; bus.lfsr_en = 0; bus.lfsr_option_sel = 0;
        bus.read_en = 0; bus.compute_en = 0; bus.READ_ADDR = '0;
        bus.scan_start = 0;
    endtask

    initial begin
        logic [TOTAL-1:0] bit_k;
        for (int r = 0; r < N_R; r++) m_state[r] = 0;
        idle_inputs();

        // 1: reset defaults
        RESET = 1; tick(); tick();
        chk("reset_LFSR", 32'(bus.LFSR), 32'h0);
        RESET = 0; bus.compute_en = 1; tick();
        chk("t1_weights", 32'(bus.LFSR), 32'h041041);
        chk("t1_busy", 32'(bus.scan_busy), 32'h0);

        // 2: per-row load then step
        idle_inputs();
        bus.lfsr_load = 1; bus.lfsr_sel = 2; bus.LFSR_REG_INIT = 5'b10100; tick();
        idle_inputs(); bus.lfsr_en = 1; tick();
        idle_inputs(); bus.compute_en = 1; tick();
        chk("t2_weights", 32'(bus.LFSR), 32'h088082);

        // 3: zero seed broadcast, then broadcast+row load in one cycle
        idle_inputs(); bus.lfsr_load_all = 1; bus.LFSR_REG_INIT = 0; tick();
        idle_inputs(); bus.compute_en = 1; tick();
        chk("t3_zero_seed", 32'(bus.LFSR), 32'h041041);
        idle_inputs(); bus.lfsr_en = 1; tick();
        idle_inputs(); bus.lfsr_load_all = 1; bus.lfsr_load = 1; bus.lfsr_sel = 1;
        bus.LFSR_REG_INIT = 0; tick();
        idle_inputs(); bus.compute_en = 1; tick();
        chk("t3_precedence", 32'(bus.LFSR), 32'h041041);
        // row load during a step: row 1 takes seed 7, others step 1 -> 2
        idle_inputs(); bus.lfsr_en = 1; bus.lfsr_load = 1; bus.lfsr_sel = 1;
        bus.LFSR_REG_INIT = 5'd7; tick();
        idle_inputs(); bus.compute_en = 1; tick();
        chk("t3_load_during_step", 32'(bus.LFSR), 32'h0821C2);

        // 4: read decode
        idle_inputs(); bus.read_en = 1; bus.READ_ADDR = 13; tick();
        chk("t4_read13", 32'(bus.LFSR), 32'h002000);
        bus.READ_ADDR = 30; tick();
        chk("t4_read_oor", 32'(bus.LFSR), 32'h0);
        bus.READ_ADDR = 5; bus.compute_en = 1; tick();
        chk("t4_read_wins", 32'(bus.LFSR), 32'h000020);

        // 5: auto scan, read overridden, restart ignored mid-scan
        idle_inputs(); bus.read_en = 1; bus.READ_ADDR = 3; bus.scan_start = 1; tick();
        chk("t5_busy_rise", 32'(bus.scan_busy), 32'h1);
        bus.scan_start = 0;
        for (int k = 0; k < TOTAL; k++) begin
            bus.scan_start = (k == 9);
            tick();
            bit_k = TOTAL'(1) << k;
            chk("t5_sweep_bit", 32'(bus.LFSR), 32'(bit_k));
            chk("t5_done_pulse", 32'(bus.scan_done), 32'(k == TOTAL - 1));
        end
        bus.scan_start = 0; tick();
        chk("t5_busy_fall", 32'(bus.scan_busy), 32'h0);
        chk("t5_read_after", 32'(bus.LFSR), 32'h000008);

        // 6: reset mid-scan, then restart from bit 0
        idle_inputs(); bus.scan_start = 1; tick();
        bus.scan_start = 0;
        for (int k = 0; k < 10; k++) tick();
        RESET = 1; tick();
        chk("t6_reset_LFSR", 32'(bus.LFSR), 32'h0);
        chk("t6_reset_busy", 32'(bus.scan_busy), 32'h0);
        RESET = 0; tick();
        chk("t6_no_done", 32'(bus.scan_done), 32'h0);
        bus.scan_start = 1; tick();
        bus.scan_start = 0; tick();
        chk("t6_restart_bit0", 32'(bus.LFSR), 32'h000001);
        for (int k = 0; k < TOTAL + 2; k++) tick();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            RESET                 = ($urandom_range(0, 99) == 0);
            bus.lfsr_load_all     = ($urandom_range(0, 15) == 0);
            bus.lfsr_load         = ($urandom_range(0, 5) == 0);
            bus.lfsr_sel          = 2'($urandom_range(0, 3));
            bus.LFSR_REG_INIT     = 5'($urandom_range(0, 31));
            bus.lfsr_en           = ($urandom_range(0, 1) == 0);
            bus.lfsr_option_sel   = ($urandom_range(0, 1) == 0);
            bus.read_en           = ($urandom_range(0, 3) == 0);
            bus.compute_en        = ($urandom_range(0, 1) == 0);
            bus.READ_ADDR         = 5'($urandom_range(0, 31));
            bus.scan_start        = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
